// File: rtl/vram_arbiter_if.sv
// Requester-side bundle for the VRAM arbiter: video fetch, CPU and aux writer.
// The slave modport faces the arbiter; the master modport faces the requesters.
interface vram_arbiter_if #(
  parameter int unsigned AW = 19
) ();
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [7:0]    vid_data;

  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;

  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic [7:0]    aux_wdata;
  logic          aux_ack;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
           aux_req, aux_addr, aux_wdata,
    output vid_ack, vid_data, cpu_ack, cpu_rdata, aux_ack
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
           aux_req, aux_addr, aux_wdata,
    input  vid_ack, vid_data, cpu_ack, cpu_rdata, aux_ack
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM sequencer shared by video fetch, CPU and an aux writer.
// Fixed priority video > CPU > aux; aux is promoted above CPU once it has lost
// AUX_STARVE CPU grants in a row. Accesses run back-to-back with no idle cycle.
module vram_arbiter #(
  parameter int unsigned AW         = 19,
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned AUX_STARVE = 4
) (
  input  logic          clk28,
  input  logic          rst,
  vram_arbiter_if.slave bus,
  output logic [AW-1:0] sram_a,
  input  logic [7:0]    sram_din,
  output logic [7:0]    sram_dout,
  output logic          sram_doe,
  output logic          sram_n_oe,
  output logic          sram_n_we,
  output logic          busy
);

  localparam int unsigned SW = $clog2(AUX_STARVE + 1);

  typedef enum logic [1:0] {StIdle, StVid, StCpu, StAux} state_e;

  state_e        state_q, state_d;
  logic [2:0]    ph_q, ph_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    vid_data_q, vid_data_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;

  logic last_ph;
  logic vid_ok, cpu_ok, aux_ok;

  // Final phase of the running access; the owner of it is masked from re-grant.
  assign last_ph = (state_q != StIdle) && (ph_q == 3'(ACC_CYCLES - 1));
  assign vid_ok  = bus.vid_req && !(last_ph && (state_q == StVid));
  assign cpu_ok  = bus.cpu_req && !(last_ph && (state_q == StCpu));
  assign aux_ok  = bus.aux_req && !(last_ph && (state_q == StAux));

  // Grant arbitration, phase sequencing and read-data capture.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    starve_d    = starve_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;

    if (last_ph && !wr_q) begin
      if (state_q == StVid) vid_data_d = sram_din;
      if (state_q == StCpu) cpu_rdata_d = sram_din;
    end

    if ((state_q == StIdle) || last_ph) begin
      ph_d    = 3'd0;
      state_d = StIdle;
      if (vid_ok) begin
        state_d = StVid;
      end else if (starve_q == SW'(AUX_STARVE)) begin
        if (aux_ok)      state_d = StAux;
        else if (cpu_ok) state_d = StCpu;
      end else begin
        if (cpu_ok)      state_d = StCpu;
        else if (aux_ok) state_d = StAux;
      end

      case (state_d)
        StVid: begin
          addr_d = bus.vid_addr;
          wr_d   = 1'b0;
        end
        StCpu: begin
          addr_d = bus.cpu_addr;
          wr_d   = bus.cpu_wr;
          dout_d = bus.cpu_wdata;
          // Only a still-unserved aux request counts as being starved.
          if (aux_ok && (starve_q != SW'(AUX_STARVE))) starve_d = starve_q + SW'(1);
        end
        StAux: begin
          addr_d   = bus.aux_addr;
          wr_d     = 1'b1;
          dout_d   = bus.aux_wdata;
          starve_d = '0;
        end
        default: ;
      endcase
    end else begin
      ph_d = ph_q + 3'd1;
    end
  end

  // State registers; reset aborts any running access without an ack.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q     <= StIdle;
      ph_q        <= 3'd0;
      starve_q    <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= 8'h00;
      vid_data_q  <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      starve_q    <= starve_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Acks are suppressed while rst is high so an aborted access never acks.
  assign bus.vid_ack   = last_ph && (state_q == StVid) && !rst;
  assign bus.cpu_ack   = last_ph && (state_q == StCpu) && !rst;
  assign bus.aux_ack   = last_ph && (state_q == StAux) && !rst;
  assign bus.vid_data  = vid_data_q;
  assign bus.cpu_rdata = cpu_rdata_q;

  // Phase 0 of a write is address setup, so n_we is held off then.
  assign busy      = (state_q != StIdle);
  assign sram_a    = addr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = busy && wr_q;
  assign sram_n_oe = !(busy && !wr_q);
  assign sram_n_we = !(busy && wr_q && (ph_q != 3'd0));

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level model of the arbitration rules.
module tb_vram_arbiter;
  localparam int unsigned AW     = 19;
  localparam int unsigned ACC    = 2;
  localparam int unsigned STARVE = 4;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk28 = ~clk28;

  vram_arbiter_if #(.AW(AW)) bus_if ();

  logic [AW-1:0] sram_a;
  logic [7:0]    sram_din, sram_dout;
  logic          sram_doe, sram_n_oe, sram_n_we, busy;

  vram_arbiter #(.AW(AW), .ACC_CYCLES(ACC), .AUX_STARVE(STARVE)) dut (
    .clk28     (clk28),
    .rst       (rst),
    .bus       (bus_if),
    .sram_a    (sram_a),
    .sram_din  (sram_din),
    .sram_dout (sram_dout),
    .sram_doe  (sram_doe),
    .sram_n_oe (sram_n_oe),
    .sram_n_we (sram_n_we),
    .busy      (busy)
  );

  // Fake SRAM contents: a fixed function of the address.
  function automatic logic [7:0] din_fn(input logic [AW-1:0] a);
    logic [7:0] r;
    if (a == 19'h1C123) r = 8'hA5;
    else r = a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
    return r;
  endfunction
  assign sram_din = din_fn(sram_a);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: current owner (0 none, 1 vid, 2 cpu, 3 aux), cycles left in its access.
  bit            m_valid = 1'b0;
  int            m_own   = 0;
  int            m_left  = 0;
  int            m_starve = 0;
  bit            m_wr    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [7:0]    m_dout  = 8'h00;
  logic [7:0]    m_vdata = 8'h00;
  logic [7:0]    m_cdata = 8'h00;
  bit            keep_v = 1'b0, keep_c = 1'b0, keep_a = 1'b0;

  task automatic model_edge();
    bit fin, v, c, a;
    int nxt;
    if (rst) begin
      m_own = 0; m_left = 0; m_starve = 0; m_wr = 1'b0; m_addr = '0;
      m_vdata = 8'h00; m_cdata = 8'h00; m_valid = 1'b1;
    end else if (m_valid) begin
      fin = (m_own != 0) && (m_left == 1);
      if (fin && !m_wr) begin
        if (m_own == 1) m_vdata = din_fn(m_addr);
        else if (m_own == 2) m_cdata = din_fn(m_addr);
      end
      if ((m_own == 0) || fin) begin
        v = bus_if.vid_req && !(fin && m_own == 1);
        c = bus_if.cpu_req && !(fin && m_own == 2);
        a = bus_if.aux_req && !(fin && m_own == 3);
        if (v) nxt = 1;
        else if (m_starve == STARVE) nxt = a ? 3 : (c ? 2 : 0);
        else nxt = c ? 2 : (a ? 3 : 0);
        if (nxt == 2 && a && m_starve < STARVE) m_starve++;
        if (nxt == 3) m_starve = 0;
        m_own  = nxt;
        m_left = ACC;
        case (nxt)
          1: begin m_addr = bus_if.vid_addr; m_wr = 1'b0; end
          2: begin m_addr = bus_if.cpu_addr; m_wr = bus_if.cpu_wr; m_dout = bus_if.cpu_wdata; end
          3: begin m_addr = bus_if.aux_addr; m_wr = 1'b1; m_dout = bus_if.aux_wdata; end
          default: ;
        endcase
      end else begin
        m_left--;
      end
    end
  endtask

  // One clock cycle: check outputs against the model, advance, then let
  // requesters react to the ack of the cycle just ended.
  task automatic step();
    bit rd, wrt, ack_v, ack_c, ack_a;
    int ph;
    #1;
    ack_v = (m_own == 1) && (m_left == 1) && !rst;
    ack_c = (m_own == 2) && (m_left == 1) && !rst;
    ack_a = (m_own == 3) && (m_left == 1) && !rst;
    if (m_valid) begin
      rd  = (m_own != 0) && !m_wr;
      wrt = (m_own != 0) && m_wr;
      ph  = ACC - m_left;
      chk("busy", 32'(busy), 32'(m_own != 0));
      chk("n_oe", 32'(sram_n_oe), 32'(!rd));
      chk("n_we", 32'(sram_n_we), 32'(!(wrt && ph != 0)));
      chk("doe", 32'(sram_doe), 32'(wrt));
      chk("sram_a", 32'(sram_a), 32'(m_addr));
      if (wrt) chk("dout", 32'(sram_dout), 32'(m_dout));
      chk("vid_ack", 32'(bus_if.vid_ack), 32'(ack_v));
      chk("cpu_ack", 32'(bus_if.cpu_ack), 32'(ack_c));
      chk("aux_ack", 32'(bus_if.aux_ack), 32'(ack_a));
      chk("vid_data", 32'(bus_if.vid_data), 32'(m_vdata));
      chk("cpu_rdata", 32'(bus_if.cpu_rdata), 32'(m_cdata));
    end
    model_edge();
    @(posedge clk28);
    #1;
    if (ack_v) begin
      if (keep_v) bus_if.vid_addr = AW'($urandom);
      else bus_if.vid_req = 1'b0;
    end
    if (ack_c) begin
      if (keep_c) begin
        bus_if.cpu_addr  = AW'($urandom);
        bus_if.cpu_wdata = 8'($urandom);
        bus_if.cpu_wr    = 1'($urandom);
      end else bus_if.cpu_req = 1'b0;
    end
    if (ack_a) begin
      if (keep_a) bus_if.aux_addr = AW'($urandom);
      else bus_if.aux_req = 1'b0;
    end
  endtask

  initial begin
    int vpos, cpos, apos, cnt;
    bit got;
    bus_if.vid_req = 1'b0; bus_if.vid_addr = '0;
    bus_if.cpu_req = 1'b0; bus_if.cpu_wr = 1'b0; bus_if.cpu_addr = '0; bus_if.cpu_wdata = 8'h00;
    bus_if.aux_req = 1'b0; bus_if.aux_addr = '0; bus_if.aux_wdata = 8'h00;

    // Reset and idle.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_n_oe", 32'(sram_n_oe), 32'd1);
    chk("t1_n_we", 32'(sram_n_we), 32'd1);
    chk("t1_doe", 32'(sram_doe), 32'd0);
    chk("t1_rdata", 32'(bus_if.cpu_rdata), 32'd0);
    chk("t1_vdata", 32'(bus_if.vid_data), 32'd0);

    // CPU read.
    bus_if.cpu_req = 1'b1; bus_if.cpu_wr = 1'b0; bus_if.cpu_addr = 19'h1C123;
    step();
    chk("t2_a_ph0", 32'(sram_a), 32'h1C123);
    chk("t2_ack_ph0", 32'(bus_if.cpu_ack), 32'd0);
    step();
    chk("t2_a_ph1", 32'(sram_a), 32'h1C123);
    chk("t2_ack_ph1", 32'(bus_if.cpu_ack), 32'd1);
    step();
    chk("t2_rdata", 32'(bus_if.cpu_rdata), 32'hA5);
    chk("t2_idle", 32'(busy), 32'd0);

    // CPU write.
    bus_if.cpu_req = 1'b1; bus_if.cpu_wr = 1'b1; bus_if.cpu_addr = 19'h00010;
    bus_if.cpu_wdata = 8'h3C;
    step();
    bus_if.cpu_wdata = 8'hFF;  // late change must not reach the running access
    chk("t3_we_ph0", 32'(sram_n_we), 32'd1);
    chk("t3_doe_ph0", 32'(sram_doe), 32'd1);
    chk("t3_dout", 32'(sram_dout), 32'h3C);
    step();
    chk("t3_we_ph1", 32'(sram_n_we), 32'd0);
    chk("t3_oe_ph1", 32'(sram_n_oe), 32'd1);
    chk("t3_dout_ph1", 32'(sram_dout), 32'h3C);
    step();

    // Three-way contention from idle.
    bus_if.vid_req = 1'b1; bus_if.vid_addr = 19'h12345;
    bus_if.cpu_req = 1'b1; bus_if.cpu_wr = 1'b0; bus_if.cpu_addr = 19'h00777;
    bus_if.aux_req = 1'b1; bus_if.aux_addr = 19'h40001; bus_if.aux_wdata = 8'h99;
    step();
    vpos = 0; cpos = 0; apos = 0;
    for (int i = 1; i <= 6; i++) begin
      chk("t4_busy", 32'(busy), 32'd1);
      if (bus_if.vid_ack) vpos = i;
      if (bus_if.cpu_ack) cpos = i;
      if (bus_if.aux_ack) apos = i;
      step();
    end
    chk("t4_vid_pos", 32'(vpos), 32'd2);
    chk("t4_cpu_pos", 32'(cpos), 32'd4);
    chk("t4_aux_pos", 32'(apos), 32'd6);
    chk("t4_idle", 32'(busy), 32'd0);

    // Starvation: video and CPU keep requesting, aux waits. Two rounds.
    keep_v = 1'b1; keep_c = 1'b1;
    bus_if.vid_req = 1'b1; bus_if.cpu_req = 1'b1; bus_if.aux_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cnt = 0; got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        if (bus_if.aux_ack) got = 1'b1;
        else if (bus_if.cpu_ack) cnt++;
        step();
      end
      chk("t5_aux_granted", 32'(got), 32'd1);
      chk("t5_cpu_grants", 32'(cnt), 32'd4);
      bus_if.aux_req = 1'b1;
    end
    keep_v = 1'b0; keep_c = 1'b0;
    bus_if.vid_req = 1'b0; bus_if.cpu_req = 1'b0; bus_if.aux_req = 1'b0;
    repeat (4) step();

    // Reset during phase 0 of an aux write; the request re-grants afterwards.
    bus_if.aux_req = 1'b1; bus_if.aux_addr = 19'h05555; bus_if.aux_wdata = 8'h6E;
    step();
    chk("t6_doe_ph0", 32'(sram_doe), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_n_we", 32'(sram_n_we), 32'd1);
    chk("t6_doe", 32'(sram_doe), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_no_ack", 32'(bus_if.aux_ack), 32'd0);
    step();
    chk("t6_regrant", 32'(busy), 32'd1);
    step();
    chk("t6_ack", 32'(bus_if.aux_ack), 32'd1);
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        keep_v = 1'($urandom); keep_c = 1'($urandom); keep_a = ($urandom_range(0, 3) == 0);
      end
      if (!bus_if.vid_req && $urandom_range(0, 3) == 0) begin
        bus_if.vid_req = 1'b1; bus_if.vid_addr = AW'($urandom);
      end
      if (!bus_if.cpu_req && $urandom_range(0, 2) == 0) begin
        bus_if.cpu_req = 1'b1; bus_if.cpu_addr = AW'($urandom);
        bus_if.cpu_wr = 1'($urandom); bus_if.cpu_wdata = 8'($urandom);
      end else if (bus_if.cpu_req && $urandom_range(0, 3) == 0) begin
        bus_if.cpu_addr = AW'($urandom); bus_if.cpu_wr = 1'($urandom);
        bus_if.cpu_wdata = 8'($urandom);
      end
      if (!bus_if.aux_req && $urandom_range(0, 4) == 0) begin
        bus_if.aux_req = 1'b1; bus_if.aux_addr = AW'($urandom); bus_if.aux_wdata = 8'($urandom);
      end
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    keep_v = 1'b0; keep_c = 1'b0; keep_a = 1'b0;
    bus_if.vid_req = 1'b0; bus_if.cpu_req = 1'b0; bus_if.aux_req = 1'b0;
    repeat (4) step();
    chk("end_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
